fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Sequencer for the instruction-fetch stage: owns the PC register, drives the byte address of the
//  combinational instruction memory and loads the IF/ID latch. Arbitrates redirect requests
//  (EX-stage branch, ID-stage jump) against hazard stalls and the run hold, inserts flush bubbles,
//  and halts on illegal fetch targets. Sits between the hazard unit/EX and the instruction memory.
// PARAMETERS
//  RESET_PC    32'h0  byte address fetched first after reset; must be word-aligned
//  IMEM_BYTES  256    instruction memory size in bytes; fetch address >= IMEM_BYTES is a fault
//  CNT_W       16     width of the retired-fetch counter
// PORTS
//  clk          in   1      single clock; all state changes on posedge
//  rst          in   1      synchronous, active-high reset
//  run          in   1      0 = fetch advances; 1 = hold PC and IF/ID (no new fetch, no bubble)
//  stall        in   1      hazard-unit stall: hold PC and IF/ID contents
//  br_taken     in   1      EX-stage branch taken (oldest redirect)
//  br_target    in   32     branch target byte address
//  jump         in   1      ID-stage jump
//  jump_target  in   32     jump target byte address
//  imem_addr    out  32     byte address to instruction memory (= pc, combinational)
//  imem_instr   in   32     instruction word read at imem_addr (combinational memory)
//  if_valid     out  1      IF/ID latch holds a real instruction
//  if_instr     out  32     IF/ID instruction (32'h0 = NOP when if_valid=0)
//  if_pc4       out  32     IF/ID: address of latched instruction + 4
//  flush_id     out  1      one-cycle pulse: kill instruction currently in ID (branch redirect)
//  fault        out  1      sticky: illegal fetch target detected
//  fetch_cnt    out  CNT_W  saturating count of instructions loaded with if_valid=1
// BEHAVIOUR
//  Reset (rst=1 at posedge): pc<=RESET_PC, state<=S_BOOT, if_valid<=0, if_instr<=0, if_pc4<=0,
//   flush_id<=0, fault<=0, fetch_cnt<=0. Reset mid-operation discards all pending redirects.
//  States: S_BOOT -> S_FETCH unconditionally after one cycle (IF/ID stays bubble);
//   S_FETCH normal; S_FLUSH one bubble cycle after any redirect; S_HALT entered on fault,
//   left only by rst.
//  Per-cycle priority in S_FETCH/S_FLUSH (highest first):
//   1 illegal target on a selected redirect (target[1:0]!=0 or target>=IMEM_BYTES): fault<=1,
//     state<=S_HALT, IF/ID<=bubble, pc unchanged.
//   2 br_taken: pc<=br_target, IF/ID<=bubble, flush_id<=1, state<=S_FLUSH. br_taken beats jump
//     in the same cycle (branch is older); stall and run are ignored.
//   3 jump: pc<=jump_target, IF/ID<=bubble, flush_id<=0, state<=S_FLUSH. Ignores stall and run.
//   4 stall or run=1: pc, IF/ID, state held; fetch_cnt held.
//   5 advance: IF/ID<={1,imem_instr,pc+4}, pc<=pc+4, state<=S_FETCH, fetch_cnt+=1.
//  S_FLUSH: the redirected target is fetched exactly as in S_FETCH; state returns to S_FETCH.
//  flush_id is high only in the cycle following a branch redirect; deasserts otherwise.
//  S_HALT: pc frozen, if_valid=0, flush_id=0, all requests ignored, fault stays 1.
//  Latency: instruction at address A appears on if_instr one cycle after imem_addr==A.
//  pc arithmetic is 32-bit modulo; sequential pc+4 reaching IMEM_BYTES is a fault (priority 1)
//   when an advance is attempted at that address.
//  fetch_cnt saturates at all-ones; no wrap.
//  imem_addr always equals pc; never X after reset.
// STRUCTURE
//  Shared package: state encoding (S_BOOT, S_FETCH, S_FLUSH, S_HALT, 2 bits), NOP word 32'h0,
//   width constant for instruction/address words.
//  One sub-module: fetch_target_chk (combinational alignment/range check, reused for branch,
//   jump and sequential targets).
// TESTING
//  Reset, run=0, no hazards: imem_addr 0,4,8,12 on successive cycles; if_valid first 1 two
//   cycles after rst falls; fetch_cnt=3 after 3 advances.
//  br_taken=1, br_target=32'h1C while pc=0x14: next pc=0x1C, flush_id pulse 1 cycle,
//   if_valid=0 one cycle, then instr at 0x1C latched with if_pc4=0x20.
//  br_taken and jump same cycle (br 0x10, jump 0x08): pc=0x10, flush_id=1.
//  stall=1 for 3 cycles at pc=0x0C: imem_addr stays 0x0C, if_instr unchanged, fetch_cnt
//   unchanged; jump during stall still redirects.
//  jump_target=32'h06 -> fault=1, S_HALT, if_valid=0; further requests ignored until rst.
//  jump_target=32'h100 (IMEM_BYTES=256) -> fault; rst asserted mid-S_FLUSH -> pc=RESET_PC,
//   fault=0, flush_id=0.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the instruction-fetch sequencer: word width, NOP encoding,
// FSM state encoding and the per-cycle action selected by the arbiter.
package fetch_ctrl_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t NOP_WORD = '0;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_FLUSH = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  // One action per cycle; the arbiter picks it, the datapath carries it out.
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_BUBBLE,
    ACT_ADV,
    ACT_BR,
    ACT_JMP,
    ACT_FAULT
  } act_e;

endpackage

// File: rtl/fetch_ctrl_target_chk.sv
// Combinational legality check for a fetch target: must be word-aligned and
// inside the instruction memory.
module fetch_target_chk
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = 256
) (
  input  word_t i_addr,
  output logic  o_illegal
);

  assign o_illegal = (i_addr[1:0] != 2'b00) || (i_addr >= IMEM_BYTES);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the instruction memory address,
// loads the IF/ID latch and arbitrates branch/jump redirects against stalls.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter word_t       RESET_PC   = 32'h0,
  parameter int unsigned IMEM_BYTES = 256,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             stall,
  input  logic             br_taken,
  input  word_t            br_target,
  input  logic             jump,
  input  word_t            jump_target,
  output word_t            imem_addr,
  input  word_t            imem_instr,
  output logic             if_valid,
  output word_t            if_instr,
  output word_t            if_pc4,
  output logic             flush_id,
  output logic             fault,
  output logic [CNT_W-1:0] fetch_cnt
);

  state_e           r_state;
  word_t            r_pc;
  logic             r_valid;
  word_t            r_instr;
  word_t            r_pc4;
  logic             r_flush;
  logic             r_fault;
  logic [CNT_W-1:0] r_cnt;

  state_e w_state_nxt;
  act_e   w_act;
  word_t  w_pc_seq;
  logic   w_br_bad;
  logic   w_jmp_bad;
  logic   w_seq_bad;

  word_t  w_pc_nxt;
  logic   w_valid_nxt;
  word_t  w_instr_nxt;
  word_t  w_pc4_nxt;
  logic   w_flush_nxt;
  logic   w_fault_nxt;
  logic   w_cnt_inc;

  assign w_pc_seq = r_pc + 32'd4;

  fetch_target_chk #(.IMEM_BYTES(IMEM_BYTES)) u_chk_br  (.i_addr(br_target),   .o_illegal(w_br_bad));
  fetch_target_chk #(.IMEM_BYTES(IMEM_BYTES)) u_chk_jmp (.i_addr(jump_target), .o_illegal(w_jmp_bad));
  fetch_target_chk #(.IMEM_BYTES(IMEM_BYTES)) u_chk_seq (.i_addr(w_pc_seq),    .o_illegal(w_seq_bad));

  // NOTE: registers hold state, so they take non-blocking assignments and the
  // reset is sampled on the clock edge like any other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_PC;
      r_valid <= 1'b0;
      r_instr <= NOP_WORD;
      r_pc4   <= '0;
      r_flush <= 1'b0;
      r_fault <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_valid <= w_valid_nxt;
      r_instr <= w_instr_nxt;
      r_pc4   <= w_pc4_nxt;
      r_flush <= w_flush_nxt;
      r_fault <= w_fault_nxt;
      if (w_cnt_inc && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Branch is older than jump, and a selected illegal target outranks everything.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_act       = ACT_HOLD;
    w_state_nxt = r_state;
    unique case (r_state)
      S_BOOT: begin
        w_act       = ACT_BUBBLE;
        w_state_nxt = S_FETCH;
      end
      S_FETCH, S_FLUSH: begin
        if (br_taken)          w_act = w_br_bad  ? ACT_FAULT : ACT_BR;
        else if (jump)         w_act = w_jmp_bad ? ACT_FAULT : ACT_JMP;
        else if (stall || run) w_act = ACT_HOLD;
        else                   w_act = w_seq_bad ? ACT_FAULT : ACT_ADV;
        unique case (w_act)
          ACT_FAULT:      w_state_nxt = S_HALT;
          ACT_BR, ACT_JMP: w_state_nxt = S_FLUSH;
          ACT_ADV:        w_state_nxt = S_FETCH;
          default:        w_state_nxt = r_state;
        endcase
      end
      default: begin
        w_act       = ACT_HOLD;
        w_state_nxt = S_HALT;
      end
    endcase
  end

  always_comb begin
    w_pc_nxt    = r_pc;
    w_valid_nxt = r_valid;
    w_instr_nxt = r_instr;
    w_pc4_nxt   = r_pc4;
    w_flush_nxt = 1'b0;
    w_fault_nxt = r_fault;
    w_cnt_inc   = 1'b0;
    if (w_act != ACT_HOLD) begin
      w_valid_nxt = 1'b0;
      w_instr_nxt = NOP_WORD;
      w_pc4_nxt   = '0;
    end
    unique case (w_act)
      ACT_ADV: begin
        w_valid_nxt = 1'b1;
        w_instr_nxt = imem_instr;
        w_pc4_nxt   = w_pc_seq;
        w_pc_nxt    = w_pc_seq;
        w_cnt_inc   = 1'b1;
      end
      ACT_BR: begin
        w_pc_nxt    = br_target;
        w_flush_nxt = 1'b1;
      end
      ACT_JMP:   w_pc_nxt    = jump_target;
      ACT_FAULT: w_fault_nxt = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr = r_pc;
  assign if_valid  = r_valid;
  assign if_instr  = r_instr;
  assign if_pc4    = r_pc4;
  assign flush_id  = r_flush;
  assign fault     = r_fault;
  assign fetch_cnt = r_cnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a vector table for the main scenario plus
// hand-written sequences for boundary faults, reset during flush and saturation.
module tb_fetch_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             run;
  logic             stall;
  logic             br_taken;
  logic [31:0]      br_target;
  logic             jump;
  logic [31:0]      jump_target;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_instr;
  logic             if_valid;
  logic [31:0]      if_instr;
  logic [31:0]      if_pc4;
  logic             flush_id;
  logic             fault;
  logic [CNT_W-1:0] fetch_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_ctrl #(.RESET_PC(32'h0), .IMEM_BYTES(256), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run(run), .stall(stall),
    .br_taken(br_taken), .br_target(br_target),
    .jump(jump), .jump_target(jump_target),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc4(if_pc4),
    .flush_id(flush_id), .fault(fault), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  assign imem_instr = mem_word(imem_addr);

  typedef struct {
    logic        run, stall, br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [31:0] e_pc4;
    logic        e_flush, e_fault;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt);
    run = r; stall = s; br_taken = b; br_target = bt; jump = j; jump_target = jt;
  endtask

  task automatic step(input logic r, input logic s, input logic b, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt);
    drive(r, s, b, bt, j, jt);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic [31:0] pc, input logic v,
                             input logic [31:0] pc4, input logic fl, input logic ft,
                             input logic [3:0] cnt);
    check({tag, " imem_addr"}, imem_addr, pc);
    check({tag, " if_valid"}, {31'b0, if_valid}, {31'b0, v});
    check({tag, " if_instr"}, if_instr, v ? mem_word(pc4 - 32'd4) : 32'h0);
    check({tag, " if_pc4"}, if_pc4, pc4);
    check({tag, " flush_id"}, {31'b0, flush_id}, {31'b0, fl});
    check({tag, " fault"}, {31'b0, fault}, {31'b0, ft});
    check({tag, " fetch_cnt"}, {28'b0, fetch_cnt}, {28'b0, cnt});
  endtask

  initial begin
    //               run s br  bt      jmp jt      e_pc    v  e_pc4   fl ft cnt
    vq.push_back('{0, 0, 0, 32'h00, 0, 32'h00, 32'h00, 0, 32'h00, 0, 0, 4'd0}); // boot
    vq.push_back('{0, 0, 0, 32'h00, 0, 32'h00, 32'h04, 1, 32'h04, 0, 0, 4'd1});
    vq.push_back('{0, 0, 0, 32'h00, 0, 32'h00, 32'h08, 1, 32'h08, 0, 0, 4'd2});
    vq.push_back('{0, 0, 0, 32'h00, 0, 32'h00, 32'h0C, 1, 32'h0C, 0, 0, 4'd3});
    vq.push_back('{0, 1, 0, 32'h00, 0, 32'h00, 32'h0C, 1, 32'h0C, 0, 0, 4'd3}); // stall x3
    vq.push_back('{0, 1, 0, 32'h00, 0, 32'h00, 32'h0C, 1, 32'h0C, 0, 0, 4'd3});
    vq.push_back('{0, 1, 0, 32'h00, 0, 32'h00, 32'h0C, 1, 32'h0C, 0, 0, 4'd3});
    vq.push_back('{1, 0, 0, 32'h00, 0, 32'h00, 32'h0C, 1, 32'h0C, 0, 0, 4'd3}); // run hold
    vq.push_back('{0, 0, 0, 32'h00, 0, 32'h00, 32'h10, 1, 32'h10, 0, 0, 4'd4});
    vq.push_back('{0, 0, 0, 32'h00, 0, 32'h00, 32'h14, 1, 32'h14, 0, 0, 4'd5});
    vq.push_back('{0, 0, 1, 32'h1C, 0, 32'h00, 32'h1C, 0, 32'h00, 1, 0, 4'd5}); // branch
    vq.push_back('{0, 0, 0, 32'h00, 0, 32'h00, 32'h20, 1, 32'h20, 0, 0, 4'd6});
    vq.push_back('{0, 0, 1, 32'h10, 1, 32'h08, 32'h10, 0, 32'h00, 1, 0, 4'd6}); // br beats jump
    vq.push_back('{0, 1, 0, 32'h00, 1, 32'h40, 32'h40, 0, 32'h00, 0, 0, 4'd6}); // jump in stall
    vq.push_back('{0, 0, 0, 32'h00, 0, 32'h00, 32'h44, 1, 32'h44, 0, 0, 4'd7});
    vq.push_back('{1, 1, 1, 32'h80, 0, 32'h00, 32'h80, 0, 32'h00, 1, 0, 4'd7}); // br ignores holds
    vq.push_back('{0, 0, 0, 32'h00, 0, 32'h00, 32'h84, 1, 32'h84, 0, 0, 4'd8});
    vq.push_back('{0, 0, 0, 32'h00, 1, 32'h06, 32'h84, 0, 32'h00, 0, 1, 4'd8}); // misaligned
    vq.push_back('{0, 0, 1, 32'h10, 0, 32'h00, 32'h84, 0, 32'h00, 0, 1, 4'd8}); // halted
    vq.push_back('{0, 0, 0, 32'h00, 1, 32'h20, 32'h84, 0, 32'h00, 0, 1, 4'd8});
    vq.push_back('{0, 0, 0, 32'h00, 0, 32'h00, 32'h84, 0, 32'h00, 0, 1, 4'd8});

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 32'h0, 0, 32'h0, 0, 0, 4'd0);
    rst = 1'b0;

    foreach (vq[i]) begin
      step(vq[i].run, vq[i].stall, vq[i].br, vq[i].bt, vq[i].jmp, vq[i].jt);
      check_state($sformatf("vec%0d", i), vq[i].e_pc, vq[i].e_valid, vq[i].e_pc4,
                  vq[i].e_flush, vq[i].e_fault, vq[i].e_cnt);
    end

    // Last legal word: advancing past it must fault without latching it.
    do_reset();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'hF8);
    check_state("jmpF8", 32'hF8, 0, 32'h0, 0, 0, 4'd0);
    step(0, 0, 0, 0, 0, 0);
    check_state("advF8", 32'hFC, 1, 32'hFC, 0, 0, 4'd1);
    step(0, 0, 0, 0, 0, 0);
    check_state("advFC", 32'hFC, 0, 32'h0, 0, 1, 4'd1);

    // Jump just past the end of memory.
    do_reset();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h100);
    check_state("jmp100", 32'h0, 0, 32'h0, 0, 1, 4'd0);

    // Illegal branch wins over a legal jump in the same cycle.
    do_reset();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h31, 1, 32'h40);
    check_state("brbad", 32'h0, 0, 32'h0, 0, 1, 4'd0);

    // Reset while in the flush cycle discards the pending redirect.
    do_reset();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h30, 0, 0);
    check_state("br30", 32'h30, 0, 32'h0, 1, 0, 4'd0);
    rst = 1'b1;
    step(0, 0, 0, 0, 1, 32'h40);
    rst = 1'b0;
    check_state("rstflush", 32'h0, 0, 32'h0, 0, 0, 4'd0);
    step(0, 0, 0, 0, 0, 0);
    check_state("postboot", 32'h0, 0, 32'h0, 0, 0, 4'd0);
    step(0, 0, 0, 0, 0, 0);
    check_state("postadv", 32'h4, 1, 32'h4, 0, 0, 4'd1);

    // Counter saturates at all-ones.
    do_reset();
    step(0, 0, 0, 0, 0, 0);
    repeat (15) step(0, 0, 0, 0, 0, 0);
    check_state("sat15", 32'h3C, 1, 32'h3C, 0, 0, 4'd15);
    repeat (5) step(0, 0, 0, 0, 0, 0);
    check_state("sat20", 32'h50, 1, 32'h50, 0, 0, 4'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
